// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: program-load port, feedback from Execute/Memory,
// and the parsed instruction fields handed to Decode.
interface fetch_pc_unit_if;
   logic        load_en;
   logic [63:0] load_addr;
   logic [7:0]  load_data;
   logic        run;
   logic        cnd;
   logic [63:0] valM;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valC;
   logic [63:0] valP;
   logic [63:0] pc;
   logic [2:0]  stat;
   logic        running;

   modport master (
      output load_en, load_addr, load_data, run, cnd, valM,
      input  icode, ifun, rA, rB, valC, valP, pc, stat, running
   );

   modport slave (
      input  load_en, load_addr, load_data, run, cnd, valM,
      output icode, ifun, rA, rB, valC, valP, pc, stat, running
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Y86-64 SEQ fetch stage: byte-addressed instruction memory, combinational
// instruction parse at pc, PC update and sticky run-state machine.
module fetch_pc_unit #(
   parameter int IMEM_BYTES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   fetch_pc_unit_if.slave bus
);
   localparam int          AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
   localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   logic [7:0]  r_mem [IMEM_BYTES];
   logic [63:0] r_pc;
   logic [1:0]  r_state;
   logic [2:0]  r_stat;

   logic [63:0] w_addr [10];
   logic [7:0]  w_byte [10];
   logic [3:0]  w_icode;
   logic [3:0]  w_ifun;
   logic        w_valid;
   logic [3:0]  w_len;
   logic        w_hasReg;
   logic        w_constAt1;
   logic        w_constAt2;
   logic [3:0]  w_rA;
   logic [3:0]  w_rB;
   logic [63:0] w_valC;
   logic [63:0] w_valP;
   logic [63:0] w_endAddr;
   logic        w_imemErr;
   logic [63:0] w_newPc;

   // Out-of-range addresses read as zero so the parse stays defined.
   always_comb begin
      for (int i = 0; i < 10; i++) begin
         w_addr[i] = r_pc + 64'(i);
         w_byte[i] = (w_addr[i] < MEM_LIMIT) ? r_mem[w_addr[i][AW-1:0]] : 8'h00;
      end
   end

   always_comb begin
      w_icode    = w_byte[0][7:4];
      w_ifun     = w_byte[0][3:0];
      w_valid    = 1'b0;
      w_len      = 4'd1;
      w_hasReg   = 1'b0;
      w_constAt1 = 1'b0;
      w_constAt2 = 1'b0;
      case (w_icode)
         4'h0, 4'h1, 4'h9: w_valid = (w_ifun == 4'h0);
         4'h2:             begin w_valid = (w_ifun <= 4'h6); w_hasReg = 1'b1; w_len = 4'd2; end
         4'h6:             begin w_valid = (w_ifun <= 4'h3); w_hasReg = 1'b1; w_len = 4'd2; end
         4'hA, 4'hB:       begin w_valid = (w_ifun == 4'h0); w_hasReg = 1'b1; w_len = 4'd2; end
         4'h7:             begin w_valid = (w_ifun <= 4'h6); w_constAt1 = 1'b1; w_len = 4'd9; end
         4'h8:             begin w_valid = (w_ifun == 4'h0); w_constAt1 = 1'b1; w_len = 4'd9; end
         4'h3, 4'h4, 4'h5: begin
            w_valid    = (w_ifun == 4'h0);
            w_hasReg   = 1'b1;
            w_constAt2 = 1'b1;
            w_len      = 4'd10;
         end
         default:          w_valid = 1'b0;
      endcase
      // An invalid instruction is treated as a bare 1-byte opcode.
      if (!w_valid) begin
         w_len      = 4'd1;
         w_hasReg   = 1'b0;
         w_constAt1 = 1'b0;
         w_constAt2 = 1'b0;
      end
   end

   always_comb begin
      w_rA   = w_hasReg ? w_byte[1][7:4] : 4'hF;
      w_rB   = w_hasReg ? w_byte[1][3:0] : 4'hF;
      w_valC = 64'd0;
      for (int i = 0; i < 8; i++) begin
         if (w_constAt1) w_valC[8*i +: 8] = w_byte[i+1];
         if (w_constAt2) w_valC[8*i +: 8] = w_byte[i+2];
      end
      w_valP    = r_pc + {60'd0, w_len};
      w_endAddr = w_valP - 64'd1;
      w_imemErr = (w_endAddr >= MEM_LIMIT) || (r_pc >= MEM_LIMIT);
   end

   always_comb begin
      w_newPc = w_valP;
      case (w_icode)
         4'h8:    w_newPc = w_valC;
         4'h7:    if (bus.cnd || (w_ifun == 4'h0)) w_newPc = w_valC;
         4'h9:    w_newPc = bus.valM;
         default: w_newPc = w_valP;
      endcase
   end

   // Memory has no reset so a program survives a reset pulse.
   always_ff @(posedge clk) begin
      if (rst_n && (r_state == ST_IDLE) && bus.load_en && (bus.load_addr < MEM_LIMIT))
         r_mem[bus.load_addr[AW-1:0]] <= bus.load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= 64'd0;
         r_state <= ST_IDLE;
         r_stat  <= STAT_AOK;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.run) r_state <= ST_RUN;
            ST_RUN: begin
               if (w_imemErr) begin
                  r_stat  <= STAT_ADR;
                  r_state <= ST_ERR;
               end else if (!w_valid) begin
                  r_stat  <= STAT_INS;
                  r_state <= ST_ERR;
               end else if (w_icode == 4'h0) begin
                  r_stat  <= STAT_HLT;
                  r_state <= ST_HALT;
               end else begin
                  r_pc <= w_newPc;
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   assign bus.icode   = w_icode;
   assign bus.ifun    = w_ifun;
   assign bus.rA      = w_rA;
   assign bus.rB      = w_rB;
   assign bus.valC    = w_valC;
   assign bus.valP    = w_valP;
   assign bus.pc      = r_pc;
   assign bus.stat    = r_stat;
   assign bus.running = (r_state == ST_RUN);
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- SEQ fetch stage plus PC register for the Y86-64 core. Sits directly upstream of Decode.
- Holds a byte-addressed instruction memory and parses the instruction at PC into icode/ifun/rA/rB/valC/valP for Decode and Execute.
- Updates PC each cycle from valP, valC or valM (fed back from Execute/Memory).
- Tracks machine status in a sticky run-state machine.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes; valid addresses are 0..IMEM_BYTES-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  program-load write strobe; honoured only in IDLE
load_addr  in  64  program-load byte address
load_data  in  8  program-load byte
run  in  1  start execution from IDLE
cnd  in  1  branch condition from Execute
valM  in  64  return address from Memory (ret)
icode  out  4  instruction code
ifun  out  4  function code
rA  out  4  register A; 4'hF if none
rB  out  4  register B; 4'hF if none
valC  out  64  constant word, little-endian; 0 if none
valP  out  64  PC + instruction length
pc  out  64  current PC register
stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
running  out  1  high in RUN state

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0): pc=0, state=IDLE, stat=1. Memory contents are not cleared. Reset mid-RUN aborts immediately to IDLE.
- Instruction lengths:
  - halt 00, nop 10, ret 90: 1 byte.
  - cmovXX 2f, OPq 6f, pushq A0, popq B0: 2 bytes (byte1 = rA:rB, high nibble rA).
  - jXX 7f, call 80: 9 bytes (Dest in bytes 1-8).
  - irmovq 30, rmmovq 40, mrmovq 50: 10 bytes (regids + 8-byte D/V).
- Field extraction:
  - Fields are combinational from pc; zero-cycle latency relative to the pc register.
  - When an instruction has no regid byte, rA=rB=F.
  - When an instruction has no constant, valC=0.
  - valP = pc + length, 64-bit wrap.
- Instruction validity:
  - icode > B is invalid.
  - ifun > 6 for 2/7 is invalid; ifun > 3 for 6 is invalid; ifun != 0 for every other icode is invalid.
  - An invalid instruction yields length 1 for valP.
- Memory error: imem_err = (pc + length - 1) >= IMEM_BYTES, or pc >= IMEM_BYTES. Out-of-range bytes read as 0.
- State IDLE:
  - load_en writes mem[load_addr] = load_data on the edge; writes with load_addr >= IMEM_BYTES are dropped.
  - run=1 moves to RUN on the next edge; pc is unchanged.
  - If load_en and run are both high, the write happens and the state moves to RUN.
- State RUN, at each edge, first match wins:
  - imem_err: stat=3, state=ERR, pc holds.
  - Invalid instruction: stat=4, state=ERR, pc holds.
  - icode=0: stat=2, state=HALT, pc holds at the halt address.
  - Otherwise pc <= new_pc, where new_pc is:
    - valC for call;
    - valC for jXX when cnd=1 or ifun=0;
    - valM for ret;
    - valP for everything else.
- HALT and ERR are terminal until reset: pc, stat and outputs stay frozen; load_en and run are ignored.
- running is high only in RUN.
- Outputs in IDLE/HALT/ERR still show the parse of mem[pc], so Decode sees stable values.

Test Plan:
- Load 30 F2 0A 00 00 00 00 00 00 00 at 0, 00 at 10; pulse run -> cycle 1: icode=3, rA=F, rB=2, valC=0xA, valP=10; next edge pc=10; following edge stat=2, pc=10, running=0.
- Load 74 ... Dest=0x20 at 0, 10 at 9, 00 at 0x20; cnd=0 -> pc goes 0->9; repeat with cnd=1 -> pc goes 0->0x20.
- Call/ret: 80 Dest=0x40 at 0; 90 at 0x40; valM=9 -> pc sequence 0, 0x40, 9.
- Load 61 23 (OPq ifun=1) then C0 -> first edge pc=2; second edge stat=4, pc=2, frozen for 5 further cycles.
- IMEM_BYTES=16: place 30 F0 at pc=8 (needs bytes 8..17) -> stat=3 at the next edge, pc=8.
- Assert rst_n low mid-RUN between edges -> pc=0, stat=1, running=0 immediately; run=1 restarts from 0 with the earlier program intact.
